stage_sequencer: RTL and testbench

//  Clocked controller that fires a chain of async-style stage blocks in order via trigger/done.
//  Per stage: drives a fixed-width control pulse, then waits for that stage's done.
//  On timeout, re-pulses the same stage; this is the synchronous equivalent of the planB retry.

---
 rtl/stage_seq_pkg.sv | 24 ++
 rtl/seq_timer.sv | 35 +++
 rtl/stage_sequencer.sv | 178 +++++++++++++++++
 tb/tb_stage_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/stage_seq_pkg.sv
// stage_seq_pkg
//   Shared types and width helpers for the stage sequencer.
//   state_t       : FSM state encoding
//   idx_w(n)      : bits needed to hold values 0..n-1 (minimum 1)
//   max_u(a, b)   : larger of two unsigned values
package stage_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PULSE = 3'd1,
    WAIT  = 3'd2,
    FIN   = 3'd3,
    ERR   = 3'd4
  } state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// seq_timer
//   Loadable down-counter with zero flag. One instance serves both the
//   control-pulse width and the completion timeout.
//   i_clk      : clock
//   i_rst      : synchronous active-high reset
//   i_load     : load i_load_val (has priority over decrement)
//   i_load_val : value to load; the count reaches zero i_load_val cycles later
//   i_dec      : decrement enable; saturates at zero
//   o_zero     : count is zero
module seq_timer #(
  parameter int unsigned W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer
//   Fires a chain of stage blocks in order. Each stage gets a fixed-width
//   one-hot control pulse, then the sequencer waits for that stage's done.
//   A timeout re-pulses the same stage until the retry budget is spent.
//
//   state | meaning
//   IDLE  | waiting for start
//   PULSE | stage_ctrl[cur_stage] high, PULSE_CYC cycles
//   WAIT  | waiting for stage_done[cur_stage], TIMEOUT cycles max
//   FIN   | all stages done; done pulse issued on exit
//   ERR   | retries exhausted; error set on exit
//
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a sequence at stage 0 (ignored unless idle)
//   stage_done : per-stage completion; only the current index is looked at
//   stage_ctrl : one-hot control pulse to the current stage
//   busy       : sequence in flight
//   done       : one-cycle pulse, all stages completed
//   error      : sticky retry-exhaustion flag
//   cur_stage  : active stage index (holds when idle)
//   retry_cnt  : retries used on the current stage
module stage_sequencer
  import stage_seq_pkg::*;
#(
  parameter int unsigned N_STAGES  = 4,
  parameter int unsigned PULSE_CYC = 3,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned MAX_RETRY = 3,
  localparam int unsigned CW = idx_w(N_STAGES),
  localparam int unsigned RW = idx_w(MAX_RETRY + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N_STAGES-1:0] stage_done,
  output logic [N_STAGES-1:0] stage_ctrl,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [CW-1:0]       cur_stage,
  output logic [RW-1:0]       retry_cnt
);

  localparam int unsigned TW = idx_w(max_u(PULSE_CYC, TIMEOUT));
  localparam logic [TW-1:0] L_PULSE = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] L_WAIT  = TW'(TIMEOUT - 1);
  localparam logic [N_STAGES-1:0] ONE = N_STAGES'(1);
  localparam logic [CW-1:0] LAST   = CW'(N_STAGES - 1);
  localparam logic [RW-1:0] MR     = RW'(MAX_RETRY);

  state_t              r_state;
  logic [N_STAGES-1:0] r_stage_ctrl;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic [CW-1:0]       r_cur;
  logic [RW-1:0]       r_retry;
  logic                r_done_seen;

  logic          w_tmr_zero;
  logic          w_accept;
  logic          w_pulse_end;
  logic          w_hit;
  logic          w_next_stage;
  logic          w_fin;
  logic          w_expire;
  logic          w_retry;
  logic          w_err;
  logic          w_load;
  logic [TW-1:0] w_load_val;
  logic          w_dec;

  // Decisions shared by the FSM and the timer. A completion (live or
  // latched during PULSE) masks expiry, so done wins a same-cycle tie.
  assign w_accept     = (r_state == IDLE) && start;
  assign w_pulse_end  = (r_state == PULSE) && w_tmr_zero;
  assign w_hit        = (r_state == WAIT) && (stage_done[r_cur] || r_done_seen);
  assign w_next_stage = w_hit && (r_cur != LAST);
  assign w_fin        = w_hit && (r_cur == LAST);
  assign w_expire     = (r_state == WAIT) && !w_hit && w_tmr_zero;
  assign w_retry      = w_expire && (r_retry < MR);
  assign w_err        = w_expire && (r_retry >= MR);

  assign w_load     = w_accept || w_pulse_end || w_next_stage || w_retry;
  assign w_load_val = w_pulse_end ? L_WAIT : L_PULSE;
  assign w_dec      = (r_state == PULSE) || (r_state == WAIT);

  seq_timer #(
    .W (TW)
  ) u_timer (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_stage_ctrl <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_cur        <= '0;
      r_retry      <= '0;
      r_done_seen  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state      <= PULSE;
            r_stage_ctrl <= ONE;
            r_busy       <= 1'b1;
            r_error      <= 1'b0;
            r_cur        <= '0;
            r_retry      <= '0;
            r_done_seen  <= 1'b0;
          end
        end
        PULSE: begin
          // A stage that finishes while still being pulsed must not be lost.
          if (stage_done[r_cur]) begin
            r_done_seen <= 1'b1;
          end
          if (w_pulse_end) begin
            r_state      <= WAIT;
            r_stage_ctrl <= '0;
          end
        end
        WAIT: begin
          if (w_next_stage) begin
            r_state      <= PULSE;
            r_cur        <= r_cur + 1'b1;
            r_retry      <= '0;
            r_stage_ctrl <= ONE << (r_cur + 1'b1);
            r_done_seen  <= 1'b0;
          end else if (w_fin) begin
            r_state     <= FIN;
            r_done_seen <= 1'b0;
          end else if (w_retry) begin
            r_state      <= PULSE;
            r_retry      <= r_retry + 1'b1;
            r_stage_ctrl <= ONE << r_cur;
            r_done_seen  <= 1'b0;
          end else if (w_err) begin
            r_state <= ERR;
          end
        end
        FIN: begin
          r_state <= IDLE;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end
        ERR: begin
          r_state <= IDLE;
          r_error <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state      <= IDLE;
          r_stage_ctrl <= '0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign stage_ctrl = r_stage_ctrl;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign cur_stage  = r_cur;
  assign retry_cnt  = r_retry;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer with default parameters
// (N_STAGES=4, PULSE_CYC=3, TIMEOUT=16, MAX_RETRY=3).
// Inputs change and outputs are sampled on the falling clock edge.
// c counts falling edges after the one at which start is driven high.
module tb_stage_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] stage_done;
  logic [3:0] stage_ctrl;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] cur_stage;
  logic [1:0] retry_cnt;

  int errors = 0;
  int checks = 0;
  int c      = 0;
  int s, ph, a, rises;
  logic prev_ctrl1;

  always #5 clk = ~clk;

  stage_sequencer #(
    .N_STAGES  (4),
    .PULSE_CYC (3),
    .TIMEOUT   (16),
    .MAX_RETRY (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stage_done (stage_done),
    .stage_ctrl (stage_ctrl),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cur_stage  (cur_stage),
    .retry_cnt  (retry_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s c=%0d observed=%0h expected=%0h", tag, c, got, exp);
    end
  endtask

  // Sequence where each stage completes on its first WAIT cycle, so stage s
  // pulses at c=4s+1..4s+3, FIN at c=17, done at c=18.
  // mode 3: stage 2 signals done only during its first PULSE cycle.
  // mode 4: stage_done[3] high while stage 0 pulses, and start re-pulsed at c=2.
  task automatic run_imm(input string tag, input int mode);
    int ts, tph;
    @(negedge clk); c = 0; start = 1'b1; stage_done = '0;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk); c = k;
      start = (mode == 4 && k == 2);
      ts  = (k - 1) / 4;
      tph = (k - 1) % 4;
      if (k == 1) chk({tag, "_err_clr"}, 32'(error), 0);
      if (k <= 16) begin
        chk({tag, "_ctrl"},  32'(stage_ctrl), (tph < 3) ? (1 << ts) : 0);
        chk({tag, "_cur"},   32'(cur_stage), ts);
        chk({tag, "_retry"}, 32'(retry_cnt), 0);
      end
      chk({tag, "_done"}, 32'(done), (k == 18) ? 1 : 0);
      chk({tag, "_busy"}, 32'(busy), (k <= 17) ? 1 : 0);
      stage_done = '0;
      if (mode == 3 && k == 9) stage_done = 4'b0100;
      else if (mode == 4 && k <= 3) stage_done = 4'b1000;
      else if (k <= 16 && tph == 3 && !(mode == 3 && ts == 2)) stage_done = 4'(1 << ts);
    end
    chk({tag, "_error"}, 32'(error), 0);
    chk({tag, "_cur_end"}, 32'(cur_stage), 3);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stage_done = '0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl",  32'(stage_ctrl), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_cur",   32'(cur_stage), 0);
    chk("rst_retry", 32'(retry_cnt), 0);
    rst = 1'b0;

    // 1: done pulses two cycles after each ctrl falls; 6 cycles per stage.
    @(negedge clk); c = 0; start = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk); c = k; start = 1'b0;
      stage_done = '0;
      if (k <= 24) begin
        s  = (k - 1) / 6;
        ph = (k - 1) % 6;
        chk("t1_ctrl", 32'(stage_ctrl), (ph < 3) ? (1 << s) : 0);
        chk("t1_cur",  32'(cur_stage), s);
        if (ph == 5) stage_done = 4'(1 << s);
      end
      chk("t1_done", 32'(done), (k == 26) ? 1 : 0);
      chk("t1_busy", 32'(busy), (k <= 25) ? 1 : 0);
    end
    chk("t1_error", 32'(error), 0);

    // 2: stage 1 never completes; four attempts 19 cycles apart, then error.
    @(negedge clk); c = 0; start = 1'b1; stage_done = 4'b0001;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); c = k; start = 1'b0;
      chk("t2_s0_ctrl", 32'(stage_ctrl), (k <= 3) ? 1 : 0);
    end
    rises = 0; prev_ctrl1 = 1'b0;
    for (int k = 5; k <= 82; k++) begin
      @(negedge clk); c = k; stage_done = '0;
      if (k <= 80) begin
        a  = (k - 5) / 19;
        ph = (k - 5) % 19;
        chk("t2_ctrl",  32'(stage_ctrl), (ph < 3) ? 2 : 0);
        chk("t2_retry", 32'(retry_cnt), a);
        chk("t2_busy",  32'(busy), 1);
      end
      if (stage_ctrl[1] && !prev_ctrl1) rises++;
      prev_ctrl1 = stage_ctrl[1];
      if (k == 81) begin
        chk("t2_err_pre",  32'(error), 0);
        chk("t2_busy_pre", 32'(busy), 1);
      end
    end
    chk("t2_error", 32'(error), 1);
    chk("t2_busy_end", 32'(busy), 0);
    chk("t2_cur",   32'(cur_stage), 1);
    chk("t2_retry_end", 32'(retry_cnt), 3);
    chk("t2_ctrl_end",  32'(stage_ctrl), 0);
    chk("t2_rises", 32'(rises), 4);

    // 3: stage 2 done latched during PULSE; also clears the sticky error.
    run_imm("t3", 3);

    // 4: foreign stage_done and start-while-busy are ignored.
    run_imm("t4", 4);

    // 5: reset (together with start) in the second PULSE cycle of stage 1.
    @(negedge clk); c = 0; start = 1'b1; stage_done = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); c = k; start = 1'b0;
      s  = (k - 1) / 4;
      ph = (k - 1) % 4;
      chk("t5_ctrl", 32'(stage_ctrl), (ph < 3) ? (1 << s) : 0);
      stage_done = (ph == 3) ? 4'(1 << s) : 4'b0;
    end
    rst = 1'b1; start = 1'b1; stage_done = '0;
    @(negedge clk); c = 7;
    chk("t5_ctrl_rst",  32'(stage_ctrl), 0);
    chk("t5_busy_rst",  32'(busy), 0);
    chk("t5_done_rst",  32'(done), 0);
    chk("t5_error_rst", 32'(error), 0);
    chk("t5_cur_rst",   32'(cur_stage), 0);
    chk("t5_retry_rst", 32'(retry_cnt), 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk); c = 8;
    chk("t5_idle_ctrl", 32'(stage_ctrl), 0);
    chk("t5_idle_busy", 32'(busy), 0);
    run_imm("t5b", 0);

    // 6: stage 0 completes on the expiry cycle of its last retry.
    @(negedge clk); c = 0; start = 1'b1; stage_done = '0;
    for (int k = 1; k <= 91; k++) begin
      @(negedge clk); c = k; start = 1'b0;
      stage_done = '0;
      if (k <= 76) begin
        a  = (k - 1) / 19;
        ph = (k - 1) % 19;
        chk("t6_ctrl",  32'(stage_ctrl), (ph < 3) ? 1 : 0);
        chk("t6_retry", 32'(retry_cnt), a);
      end else if (k <= 88) begin
        s  = 1 + (k - 77) / 4;
        ph = (k - 77) % 4;
        chk("t6_ctrl_b", 32'(stage_ctrl), (ph < 3) ? (1 << s) : 0);
        chk("t6_cur_b",  32'(cur_stage), s);
        chk("t6_retry_b", 32'(retry_cnt), 0);
      end
      chk("t6_error", 32'(error), 0);
      chk("t6_done",  32'(done), (k == 90) ? 1 : 0);
      if (k == 76) stage_done = 4'b0001;
      if (k == 80) stage_done = 4'b0010;
      if (k == 84) stage_done = 4'b0100;
      if (k == 88) stage_done = 4'b1000;
    end
    chk("t6_busy_end", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
